// File: rtl/i2c_target_regfile.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// i2c_target_regfile
//
// I2C target (responder) with a small 8-bit register file behind a 16-bit
// big-endian register index. This is the counterpart of the sensor
// configuration initiator. It is used as a bench model and as an on-chip
// loopback target while bringing up the init sequencer.
//
// Protocol handled:
//   START, 7-bit address + R/W, ACK
//   write: index[15:8], ACK, index[7:0], ACK, data bytes (auto-increment)
//   read : data bytes from the current pointer (auto-increment) until NACK
//   A repeated START keeps the pointer, so the usual combined transfer
//   works: write the index, repeated START, then read.
//
// Ports:
//   clk      system clock; must run at least 20x the SCL rate
//   rst_n    synchronous active-low reset
//   scl_i    SCL line level
//   sda_i    SDA line level
//   sda_oe   1 = pull SDA low (open-drain), 0 = release
//   wr_vld   one-cycle pulse for each accepted data byte write
//   wr_addr  full 16-bit register index of that write
//   wr_data  data byte of that write
//   busy     high from an addressed START until STOP or NACK release
// ---------------------------------------------------------------------------
module i2c_target_regfile #(
  parameter logic [6:0]  SLAVE_ADDR  = 7'd16,
  parameter int          REG_DEPTH   = 256,
  parameter logic [15:0] REG_BASE    = 16'h0100,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic        wr_vld,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy
);

  localparam int IDX_W = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_RA_HI,
    S_RA_LO,
    S_WDATA,
    S_RDATA
  } state_t;

  // An index is backed by storage when REG_BASE <= idx < REG_BASE+REG_DEPTH.
  // The sum is done in 17 bits so a window touching 16'hFFFF cannot wrap.
  function automatic logic in_range(input logic [15:0] idx);
    logic [16:0] lo;
    logic [16:0] hi;
    lo = {1'b0, REG_BASE};
    hi = {1'b0, REG_BASE} + 17'(REG_DEPTH);
    return ({1'b0, idx} >= lo) && ({1'b0, idx} < hi);
  endfunction

  // ---- stage p0: line synchronizers and edge/condition detection ----------
  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_s;
  logic                   sda_s;

  // Reset to the idle bus level (both lines high) so leaving reset never
  // manufactures a false edge or START/STOP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;

  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  // ---- stage p1: protocol FSM ---------------------------------------------
  state_t      state, state_nx;
  logic [3:0]  bit_cnt, bit_cnt_nx;   // bits shifted so far in this byte
  logic [6:0]  shreg, shreg_nx;       // first seven received bits
  logic        ack_slot, ack_slot_nx; // inside the 9th (ACK) bit we drive
  logic        rw, rw_nx;
  logic        busy_nx;
  logic        sda_oe_nx;
  logic [15:0] ptr, ptr_nx;
  logic [7:0]  idx_hi, idx_hi_nx;
  logic        wr_vld_nx;
  logic [15:0] wr_addr_nx;
  logic [7:0]  wr_data_nx;

  logic [7:0]       mem [REG_DEPTH];
  logic             mem_we;
  logic [7:0]       rx_byte;
  logic [7:0]       rd_byte;

  // Complete byte as of the 8th rising edge (current bit not yet registered).
  assign rx_byte = {shreg, sda_s};
  assign rd_byte = in_range(ptr) ? mem[ptr[IDX_W-1:0]] : 8'h00;

  always_comb begin
    state_nx    = state;
    bit_cnt_nx  = bit_cnt;
    shreg_nx    = shreg;
    ack_slot_nx = ack_slot;
    rw_nx       = rw;
    busy_nx     = busy;
    sda_oe_nx   = sda_oe;
    ptr_nx      = ptr;
    idx_hi_nx   = idx_hi;
    wr_vld_nx   = 1'b0;
    wr_addr_nx  = wr_addr;
    wr_data_nx  = wr_data;
    mem_we      = 1'b0;

    if (stop_det) begin
      state_nx    = S_IDLE;
      bit_cnt_nx  = 4'd0;
      ack_slot_nx = 1'b0;
      sda_oe_nx   = 1'b0;
      busy_nx     = 1'b0;
    end else if (start_det) begin
      // Covers repeated START too; ptr is deliberately left alone.
      state_nx    = S_ADDR;
      bit_cnt_nx  = 4'd0;
      ack_slot_nx = 1'b0;
      sda_oe_nx   = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
        end

        S_RDATA: begin
          if (scl_rise) begin
            if (bit_cnt < 4'd8) begin
              bit_cnt_nx = bit_cnt + 4'd1;
            end else begin
              // 9th bit: initiator ACK/NACK. The pointer advances either way.
              ptr_nx     = ptr + 16'd1;
              bit_cnt_nx = 4'd0;
              if (sda_s) begin
                state_nx = S_IDLE;
                busy_nx  = 1'b0;
              end
            end
          end else if (scl_fall) begin
            // bit_cnt counts bits already clocked out, so the next bit to
            // present is rd_byte[7-bit_cnt]; after 8 bits release for ACK.
            if (bit_cnt < 4'd8) begin
              sda_oe_nx = ~rd_byte[~bit_cnt[2:0]];
            end else begin
              sda_oe_nx = 1'b0;
            end
          end
        end

        default: begin
          // Receive states: ADDR, RA_HI, RA_LO, WDATA.
          if (scl_rise && !ack_slot && (bit_cnt < 4'd8)) begin
            shreg_nx   = rx_byte[6:0];
            bit_cnt_nx = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              case (state)
                S_ADDR: begin
                  if (rx_byte[7:1] == SLAVE_ADDR) begin
                    rw_nx   = rx_byte[0];
                    busy_nx = 1'b1;
                  end else begin
                    state_nx   = S_IDLE;
                    bit_cnt_nx = 4'd0;
                    busy_nx    = 1'b0;
                  end
                end
                S_RA_HI: idx_hi_nx = rx_byte;
                S_RA_LO: ptr_nx    = {idx_hi, rx_byte};
                S_WDATA: begin
                  wr_vld_nx  = 1'b1;
                  wr_addr_nx = ptr;
                  wr_data_nx = rx_byte;
                  mem_we     = in_range(ptr);
                  ptr_nx     = ptr + 16'd1;
                end
                default: begin
                end
              endcase
            end
          end else if (scl_fall && (bit_cnt == 4'd8)) begin
            if (!ack_slot) begin
              sda_oe_nx   = 1'b1;
              ack_slot_nx = 1'b1;
            end else begin
              ack_slot_nx = 1'b0;
              bit_cnt_nx  = 4'd0;
              sda_oe_nx   = 1'b0;
              case (state)
                S_ADDR: begin
                  if (rw) begin
                    // The fall that ends the address ACK also presents the
                    // first read bit.
                    state_nx  = S_RDATA;
                    sda_oe_nx = ~rd_byte[7];
                  end else begin
                    state_nx = S_RA_HI;
                  end
                end
                S_RA_HI: state_nx = S_RA_LO;
                S_RA_LO: state_nx = S_WDATA;
                default: state_nx = state;
              endcase
            end
          end
        end
      endcase
    end
  end

  // ---- stage p2: registered state and outputs -----------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      bit_cnt  <= 4'd0;
      shreg    <= 7'd0;
      ack_slot <= 1'b0;
      rw       <= 1'b0;
      busy     <= 1'b0;
      sda_oe   <= 1'b0;
      ptr      <= 16'd0;
      idx_hi   <= 8'd0;
      wr_vld   <= 1'b0;
      wr_addr  <= 16'd0;
      wr_data  <= 8'd0;
    end else begin
      state    <= state_nx;
      bit_cnt  <= bit_cnt_nx;
      shreg    <= shreg_nx;
      ack_slot <= ack_slot_nx;
      rw       <= rw_nx;
      busy     <= busy_nx;
      sda_oe   <= sda_oe_nx;
      ptr      <= ptr_nx;
      idx_hi   <= idx_hi_nx;
      wr_vld   <= wr_vld_nx;
      wr_addr  <= wr_addr_nx;
      wr_data  <= wr_data_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (mem_we) begin
      mem[ptr[IDX_W-1:0]] <= rx_byte;
    end
  end

endmodule

// File: tb/tb_i2c_target_regfile.sv
`timescale 1ns/1ps
module tb_i2c_target_regfile;

  localparam int Q = 8;  // clk cycles per quarter SCL period

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl = 1'b1;
  logic        m_sda = 1'b1;
  logic        sda_oe;
  logic        wr_vld;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  wire         sda_line = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_regfile #(
    .SLAVE_ADDR (7'd16),
    .REG_DEPTH  (256),
    .REG_BASE   (16'h0100),
    .SYNC_STAGES(2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .scl_i  (scl),
    .sda_i  (sda_line),
    .sda_oe (sda_oe),
    .wr_vld (wr_vld),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .busy   (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Bus monitor: counts write pulses and cycles where the target pulls SDA.
  int          wr_cnt = 0;
  int          oe_cnt = 0;
  logic [15:0] last_wa = 16'h0;
  logic [7:0]  last_wd = 8'h0;

  always @(negedge clk) begin
    if (wr_vld) begin
      wr_cnt  = wr_cnt + 1;
      last_wa = wr_addr;
      last_wd = wr_data;
    end
    if (sda_oe) oe_cnt = oe_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    if (!scl) begin
      m_sda = 1'b1; wait_q();
      scl   = 1'b1; wait_q();
    end
    m_sda = 1'b0; wait_q();
    scl   = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_q();
    scl   = 1'b1; wait_q();
    m_sda = 1'b1; wait_q();
  endtask

  // One bit: drive level in the low phase, sample the line mid-high.
  task automatic send_bit(input logic b, output logic s);
    m_sda = b;    wait_q();
    scl   = 1'b1; wait_q();
    s     = sda_line; wait_q();
    scl   = 1'b0; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic ack, output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1, s);
      d = {d[6:0], s};
    end
    send_bit(~ack, s);
  endtask

  // Combined transfer: write index, repeated START, read one byte with NACK.
  task automatic read_reg(input logic [15:0] idx, output logic [7:0] d, output logic all_ack);
    logic a0, a1, a2, a3;
    i2c_start();
    send_byte(8'h20, a0);
    send_byte(idx[15:8], a1);
    send_byte(idx[7:0], a2);
    i2c_start();
    send_byte(8'h21, a3);
    recv_byte(1'b0, d);
    i2c_stop();
    all_ack = a0 & a1 & a2 & a3;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        a, a1, a2, a3, s;
    logic [7:0]  d, d1, d2;
    logic [7:0]  pat;
    int          wc0, oc0;

    // ---- reset state ----
    repeat (5) @(negedge clk);
    chk("rst_sda_oe",  sda_oe,  1'b0);
    chk("rst_wr_vld",  wr_vld,  1'b0);
    chk("rst_wr_addr", wr_addr, 16'h0000);
    chk("rst_wr_data", wr_data, 8'h00);
    chk("rst_busy",    busy,    1'b0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // ---- single write: 0x0100 <= 0x01 ----
    wc0 = wr_cnt;
    i2c_start();
    send_byte(8'h20, a);  chk("w1_ack_addr", a, 1'b1);
    chk("w1_busy_hi", busy, 1'b1);
    send_byte(8'h01, a);  chk("w1_ack_hi", a, 1'b1);
    send_byte(8'h00, a);  chk("w1_ack_lo", a, 1'b1);
    send_byte(8'h01, a);  chk("w1_ack_data", a, 1'b1);
    chk("w1_busy_pre_stop", busy, 1'b1);
    i2c_stop();
    chk("w1_busy_stop", busy, 1'b0);
    chk("w1_wr_cnt", wr_cnt - wc0, 1);
    chk("w1_wr_addr", last_wa, 16'h0100);
    chk("w1_wr_data", last_wd, 8'h01);

    // ---- burst write 0x0104..0x0106 then combined read-back ----
    wc0 = wr_cnt;
    i2c_start();
    send_byte(8'h20, a);
    send_byte(8'h01, a1);
    send_byte(8'h04, a2);
    send_byte(8'hAA, a3); chk("bw_ack_aa", a3, 1'b1);
    send_byte(8'h55, a3); chk("bw_ack_55", a3, 1'b1);
    send_byte(8'h0F, a3); chk("bw_ack_0f", a3, 1'b1);
    i2c_stop();
    chk("bw_hdr_acks", {a, a1, a2}, 3'b111);
    chk("bw_wr_cnt", wr_cnt - wc0, 3);
    chk("bw_last_addr", last_wa, 16'h0106);

    i2c_start();
    send_byte(8'h20, a);
    send_byte(8'h01, a1);
    send_byte(8'h04, a2);
    i2c_start();
    send_byte(8'h21, a3);
    chk("br_hdr_acks", {a, a1, a2, a3}, 4'b1111);
    recv_byte(1'b1, d);  chk("br_byte0", d,  8'hAA);
    recv_byte(1'b1, d1); chk("br_byte1", d1, 8'h55);
    recv_byte(1'b0, d2); chk("br_byte2", d2, 8'h0F);
    chk("br_sda_released", sda_oe, 1'b0);
    chk("br_busy_nack", busy, 1'b0);
    i2c_stop();

    // ---- address mismatch ----
    wc0 = wr_cnt;
    oc0 = oe_cnt;
    i2c_start();
    send_byte(8'h34, a);  chk("mm_no_ack", a, 1'b0);
    chk("mm_oe_quiet", oe_cnt - oc0, 0);
    send_byte(8'h01, a);
    send_byte(8'h00, a1);
    send_byte(8'h99, a2);
    chk("mm_ignored_acks", {a, a1, a2}, 3'b000);
    chk("mm_no_write", wr_cnt - wc0, 0);
    chk("mm_busy", busy, 1'b0);
    i2c_stop();

    // ---- out-of-range index 0x3000 ----
    wc0 = wr_cnt;
    i2c_start();
    send_byte(8'h20, a);
    send_byte(8'h30, a1);
    send_byte(8'h00, a2);
    send_byte(8'h77, a3);
    i2c_stop();
    chk("oor_acks", {a, a1, a2, a3}, 4'b1111);
    chk("oor_wr_cnt", wr_cnt - wc0, 1);
    chk("oor_wr_addr", last_wa, 16'h3000);
    chk("oor_wr_data", last_wd, 8'h77);
    read_reg(16'h3000, d, a);
    chk("oor_read", d, 8'h00);
    chk("oor_read_acks", a, 1'b1);
    read_reg(16'h0100, d, a);
    chk("oor_0100_kept", d, 8'h01);

    // ---- reset during the ACK slot of a data byte ----
    wc0 = wr_cnt;
    pat = 8'h5A;
    i2c_start();
    send_byte(8'h20, a);
    send_byte(8'h01, a1);
    send_byte(8'h00, a2);
    for (int i = 7; i >= 0; i--) send_bit(pat[i], s);
    m_sda = 1'b1; wait_q();
    scl   = 1'b1; wait_q();
    chk("rs_ack_driven", sda_oe, 1'b1);
    chk("rs_wr_data", last_wd, 8'h5A);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rs_sda_release", sda_oe, 1'b0);
    chk("rs_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_q();
    scl = 1'b0; wait_q();
    i2c_stop();
    read_reg(16'h0100, d, a);
    chk("rs_0100_cleared", d, 8'h00);
    chk("rs_read_acks", a, 1'b1);
    read_reg(16'h0104, d, a);
    chk("rs_0104_cleared", d, 8'h00);

    // ---- STOP right after the address ACK ----
    wc0 = wr_cnt;
    i2c_start();
    send_byte(8'h20, a);  chk("sa_ack", a, 1'b1);
    i2c_stop();
    chk("sa_busy", busy, 1'b0);
    chk("sa_no_write", wr_cnt - wc0, 0);
    i2c_start();
    send_byte(8'h20, a);  chk("sa_next_ack", a, 1'b1);
    send_byte(8'h01, a1);
    send_byte(8'h08, a2);
    send_byte(8'h3C, a3);
    i2c_stop();
    chk("sa_next_acks", {a1, a2, a3}, 3'b111);
    chk("sa_next_write", wr_cnt - wc0, 1);
    read_reg(16'h0108, d, a);
    chk("sa_readback", d, 8'h3C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
